// File: rtl/sha_miner_mm.sv
// Purpose : Avalon-MM register front end for an external SHA-256 core; single hash or nonce-search mining.
// Latency : reads return one cycle after chipselect&read; each hash iteration is 1 (issue) + L (core) + 1 (check) cycles.
// Backpr. : no wait states; while busy, writes to MSG/TARGET/MAX_ITER and start writes are dropped.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   chipselect/write/read Avalon slave strobes, address (word), writedata, readdata (registered)
//   irq                   level interrupt = done & irq_en
//   core_start/core_block start pulse and 512-bit message block driven to the core
//   core_digest/core_done 256-bit result, valid in the single cycle core_done is high
module sha_miner_mm #(
   parameter int NONCE_IDX = 3,
   parameter int ADDR_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic              core_start,
   output logic [511:0]      core_block,
   input  logic [255:0]      core_digest,
   input  logic              core_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] A_DIG   = ADDR_W'(16);
   localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(24);
   localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(25);
   localparam logic [ADDR_W-1:0] A_TGT   = ADDR_W'(26);
   localparam logic [ADDR_W-1:0] A_MAXI  = ADDR_W'(27);
   localparam logic [ADDR_W-1:0] A_ITER  = ADDR_W'(28);
   localparam logic [3:0]        NIDX    = 4'(NONCE_IDX);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_msg [16];
   logic [255:0]  r_digest;
   logic [8:0]    r_target;
   logic [31:0]   r_max_iter;
   logic [31:0]   r_iter;
   logic          r_done;
   logic          r_found;
   logic          r_exh;
   logic          r_mode;
   logic          r_irq_en;
   logic          r_abort_pend;
   logic [31:0]   r_readdata;

   logic          w_wr;
   logic          w_rd;
   logic          w_busy;
   logic          w_cfg_wr;
   logic          w_ctrl_wr;
   logic          w_start;
   logic          w_abort_set;
   logic          w_w1c;
   logic          w_capture;
   logic [255:0]  w_mask;
   logic          w_found;
   logic [31:0]   w_max_eff;
   logic          w_limit;
   logic          w_core_start;
   logic          w_to_idle;
   logic          w_exh_set;
   logic          w_step;
   logic [31:0]   w_rdata;

   assign w_wr        = chipselect & write;
   assign w_rd        = chipselect & read;
   assign w_busy      = (r_state != S_IDLE);
   assign w_cfg_wr    = w_wr & ~w_busy;
   assign w_ctrl_wr   = w_wr & (address == A_CTRL);
   // A combined start+abort write never launches a hash.
   assign w_start     = w_ctrl_wr & ~w_busy & writedata[0] & ~writedata[2];
   assign w_abort_set = w_ctrl_wr & w_busy & writedata[2];
   assign w_w1c       = w_wr & (address == A_STAT) & writedata[1];
   assign w_capture   = (r_state == S_WAIT) & core_done;

   // Top-TARGET-bits mask; a shift by 256 yields all ones, TARGET = 0 yields an empty mask (always found).
   assign w_mask      = ~({256{1'b1}} >> r_target);
   assign w_found     = ((r_digest & w_mask) == 256'd0);
   assign w_max_eff   = (r_max_iter == 32'd0) ? 32'd1 : r_max_iter;
   assign w_limit     = (r_iter >= w_max_eff);

   always_comb begin
      w_state_nxt  = r_state;
      w_core_start = 1'b0;
      w_to_idle    = 1'b0;
      w_exh_set    = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_core_start = 1'b1;
            w_state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (r_abort_pend || !r_mode || w_found || w_limit) begin
               w_state_nxt = S_IDLE;
               w_to_idle   = 1'b1;
               // An abort suppresses the exhausted flag even if the limit was also hit.
               w_exh_set   = ~r_abort_pend & r_mode & ~w_found & w_limit;
            end else begin
               w_step      = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_rdata = 32'd0;
      if (address < A_DIG) begin
         w_rdata = r_msg[address[3:0]];
      end else if (address < A_CTRL) begin
         w_rdata = r_digest[32*address[2:0] +: 32];
      end else if (address == A_CTRL) begin
         w_rdata = {28'd0, r_irq_en, 1'b0, r_mode, 1'b0};
      end else if (address == A_STAT) begin
         w_rdata = {28'd0, r_exh, r_found, r_done, w_busy};
      end else if (address == A_TGT) begin
         w_rdata = {23'd0, r_target};
      end else if (address == A_MAXI) begin
         w_rdata = r_max_iter;
      end else if (address == A_ITER) begin
         w_rdata = r_iter;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_msg[i] <= 32'd0;
         r_digest     <= 256'd0;
         r_target     <= 9'd0;
         r_max_iter   <= 32'd0;
         r_iter       <= 32'd0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_exh        <= 1'b0;
         r_mode       <= 1'b0;
         r_irq_en     <= 1'b0;
         r_abort_pend <= 1'b0;
         r_readdata   <= 32'd0;
      end else begin
         // Host MSG writes only happen when idle, nonce steps only when busy: never both.
         if (w_cfg_wr && (address < A_DIG)) r_msg[address[3:0]] <= writedata;
         if (w_step) r_msg[NIDX] <= r_msg[NIDX] + 32'd1;

         if (w_cfg_wr && (address == A_TGT))
            r_target <= (writedata > 32'd256) ? 9'd256 : writedata[8:0];
         if (w_cfg_wr && (address == A_MAXI)) r_max_iter <= writedata;

         if (w_ctrl_wr) r_irq_en <= writedata[3];
         if (w_start)   r_mode   <= writedata[1];

         if (w_capture) r_digest <= core_digest;

         if (w_start)        r_iter <= 32'd0;
         else if (w_capture) r_iter <= r_iter + 32'd1;

         // Completion outranks a same-cycle W1C clear.
         if (w_to_idle) begin
            r_done  <= 1'b1;
            r_found <= w_found;
            r_exh   <= w_exh_set;
         end else if (w_start || w_w1c) begin
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_exh   <= 1'b0;
         end

         if (w_to_idle)        r_abort_pend <= 1'b0;
         else if (w_abort_set) r_abort_pend <= 1'b1;

         if (w_rd) r_readdata <= w_rdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_block
         assign core_block[32*gi +: 32] = r_msg[gi];
      end
   endgenerate

   assign core_start = w_core_start;
   assign readdata   = r_readdata;
   assign irq        = r_done & r_irq_en;

endmodule

// File: doc/sha_miner_mm.md
# sha_miner_mm

Parametrised Avalon-MM front end for the SHA-256 core: a register file that holds one 512-bit message block and exposes readable digest and status. It supports single-hash mode and a nonce-search ("mining") mode. In mining mode it increments a nonce word and re-hashes until the digest has the required number of leading zero bits or an iteration limit is reached. It sits between the HPS lightweight bridge and an externally instantiated `sha256_module`, whose ports it drives.

## Interface
- `NONCE_IDX`, default 3: message word (0-15) used as the nonce.
- `ADDR_W`, default 5: word address width; must be at least 5.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: write strobe, qualified by `chipselect`.
- `read` in 1: read strobe, qualified by `chipselect`.
- `address` in ADDR_W: word address.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_block` out 512: message block; word i maps to bits [32i+31:32i].
- `core_digest` in 256: core result.
- `core_done` in 1: one-cycle pulse; `core_digest` is valid in the same cycle.

## Operation
- Register map (word addresses):
  - 0-15 `MSG`: read/write.
  - 16-23 `DIGEST`: read-only; word j = latched digest [32j+31:32j].
  - 24 `CTRL`: write bit0 start, bit1 mode (1 = mine), bit2 abort, bit3 irq_en. Read returns {irq_en, mode} in bits 3 and 1.
  - 25 `STATUS`: bit0 busy, bit1 done, bit2 found, bit3 exhausted. Writing 1 to bit1 clears done, found and exhausted.
  - 26 `TARGET`: 9 bits; values above 256 clamp to 256.
  - 27 `MAX_ITER`: 32 bits; 0 behaves as 1.
  - 28 `ITER`: read-only; count of completed hashes.
  - 29-31: read 0, writes ignored.
- FSM states: IDLE, ISSUE, WAIT, CHECK.
  - IDLE → ISSUE on a start write. That write also clears done, found, exhausted and ITER, and latches mode.
  - ISSUE: `core_start` = 1 for exactly one cycle, then → WAIT.
  - WAIT → CHECK on `core_done`. Latch `core_digest` into DIGEST and increment ITER.
  - CHECK: found = (`digest[255 -: TARGET]` == 0). TARGET = 0 always counts as found.
    - Single mode → IDLE.
    - Mine mode, found → IDLE. MSG[NONCE_IDX] keeps the winning nonce.
    - Mine mode, ITER ≥ MAX_ITER → IDLE with exhausted = 1.
    - Otherwise MSG[NONCE_IDX] += 1 (mod 2^32, wraps) and → ISSUE.
    - Every transition to IDLE sets done = 1.
- busy = (state ≠ IDLE).
- While busy:
  - Writes to MSG, TARGET and MAX_ITER are ignored.
  - A start write is ignored.
- Abort write while busy: sets a pending flag. The FSM finishes the current WAIT, and on the next CHECK it goes to IDLE with done = 1, found evaluated normally, exhausted = 0. Abort in IDLE has no effect.
- Start and abort in the same write while IDLE: no start.
- irq = done & irq_en.
- Done set and a W1C clear in the same cycle: set wins.

## Timing
- Reset values:
  - All outputs 0.
  - MSG, DIGEST, TARGET, MAX_ITER, ITER, flags: 0.
  - State: IDLE.
  - Reset mid-hash returns to IDLE immediately; any later `core_done` is ignored in IDLE.
- Read latency is 1: `readdata` is valid in the cycle after `chipselect & read`. Otherwise `readdata` holds its last value.
- Writes take effect at the clock edge where they are sampled.
- Start written at edge T:
  - busy = 1 and `core_start` = 1 during cycle T+1.
  - `core_start` = 0 from T+2.
- Hash latency L = cycles from `core_start` to `core_done`.
  - Each iteration is 1 (ISSUE) + L (WAIT) + 1 (CHECK) cycles.
  - In single mode, done = 1 two cycles after `core_done`.
- The nonce increment and the next `core_start` are back-to-back. The incremented `core_block` is stable in the cycle where `core_start` is high.
- `core_block` is combinationally equal to MSG at all times.

## Test plan
- Single hash:
  - Stimulus: MSG = padded "abc", mode 0, start.
  - Response: one `core_start` pulse; done = 1, ITER = 1; DIGEST reads ba7816bf…f20015ad (word 7 = 0xba7816bf).
- Mining success:
  - Stimulus: TARGET = 4, MAX_ITER = 100, nonce = 0, core model returns digest with top nibble 0 when nonce = 5.
  - Response: found = 1, MSG[NONCE_IDX] = 5, ITER = 6, exhausted = 0.
- Exhaustion and wrap:
  - Stimulus: nonce = 0xFFFFFFFE, MAX_ITER = 3, TARGET = 256, digest never zero.
  - Response: nonces hashed are FFFFFFFE, FFFFFFFF, 0; exhausted = 1, found = 0.
- Abort:
  - Stimulus: start mining with MAX_ITER = 1000, write abort during WAIT of iteration 2.
  - Response: exactly 2 `core_done` pulses consumed; done = 1, ITER = 2, no further `core_start`.
- Busy protection and irq:
  - Stimulus: with irq_en = 1, write MSG[0] and start while busy.
  - Response: both ignored. irq rises with done; a W1C write to STATUS bit1 drops irq the next cycle.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle, then pulse `core_done`.
  - Response: all registers 0, busy = 0, DIGEST stays 0.
